// File: rtl/mux_rr_sched.sv
// rtl/mux_rr_sched.sv - round-robin scheduler driving a 4:1 mux select with valid/ready and per-channel ack
// Optional multi-beat grants are compiled in with SCHED_BURST_EN.
module mux_rr_sched #(
    parameter int BURST_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       out_ready,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       out_valid,
    output logic [3:0] ack
);

    typedef enum logic {IDLE, GRANT} state_t;

`ifdef SCHED_BURST_EN
    localparam int MAX_BEATS = BURST_LEN;
`else
    // single-beat grants; BURST_LEN/BURST_LEN keeps the parameter referenced and evaluates to 1
    localparam int MAX_BEATS = BURST_LEN / BURST_LEN;
`endif

    state_t     state;
    state_t     next_state;
    logic [1:0] ptr;
    logic [1:0] next_ptr;
    logic [1:0] next_sel;
    logic [3:0] next_grant;
    logic [3:0] beat_cnt;
    logic [3:0] next_cnt;
    logic       accept;
    logic       burst_cont;

    // {found, index}: first set bit of r at or above base, wrapping 3 -> 0
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [2:0] result;
        logic [1:0] cand;
        result = {1'b0, base};
        for (int i = 3; i >= 0; i--) begin
            cand = base + 2'(i);
            if (r[cand]) begin
                result = {1'b1, cand};
            end
        end
        return result;
    endfunction

    assign burst_cont = ({1'b0, beat_cnt} + 5'd1) < 5'(MAX_BEATS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= 2'd0;
            grant    <= 4'd0;
            ptr      <= 2'd0;
            beat_cnt <= 4'd0;
        end else begin
            state    <= next_state;
            sel      <= next_sel;
            grant    <= next_grant;
            ptr      <= next_ptr;
            beat_cnt <= next_cnt;
        end
    end

    always_comb begin
        logic [2:0] pick;
        logic       do_arb;
        logic [3:0] arb_req;
        logic [1:0] arb_base;
        next_state = state;
        next_sel   = sel;
        next_grant = grant;
        next_ptr   = ptr;
        next_cnt   = beat_cnt;
        do_arb     = 1'b0;
        arb_req    = req;
        arb_base   = ptr;
        case (state)
            IDLE: begin
                do_arb = |req;
            end
            GRANT: begin
                if (accept) begin
                    next_ptr = sel + 2'd1;
                    if (burst_cont) begin
                        next_cnt = beat_cnt + 4'd1;
                    end else begin
                        do_arb   = 1'b1;
                        arb_req  = req & ~grant;
                        arb_base = sel + 2'd1;
                    end
                end else if (!req[sel]) begin
                    // early burst end or a requester dropping before its first beat
                    do_arb  = 1'b1;
                    arb_req = req & ~grant;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        pick = rr_pick(arb_req, arb_base);
        if (do_arb) begin
            next_cnt = 4'd0;
            if (pick[2]) begin
                next_state = GRANT;
                next_sel   = pick[1:0];
                next_grant = 4'b0001 << pick[1:0];
            end else begin
                next_state = IDLE;
                next_grant = 4'd0;
            end
        end
    end

    always_comb begin
        out_valid = (state == GRANT) && req[sel];
        accept    = out_valid && out_ready;
        ack       = accept ? grant : 4'd0;
    end

endmodule

// File: tb/tb_mux_rr_sched.sv
// tb/tb_mux_rr_sched.sv - randomized and directed bench for mux_rr_sched against a behavioural model
module tb_mux_rr_sched;

    localparam int BL = 4;
`ifdef SCHED_BURST_EN
    localparam int MAXB = BL;
`else
    localparam int MAXB = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'd0;
    logic       out_ready = 1'b0;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       out_valid;
    logic [3:0] ack;

    mux_rr_sched #(.BURST_LEN(BL)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel),
        .grant     (grant),
        .out_valid (out_valid),
        .ack       (ack)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // model: granted channel (-1 when idle), priority pointer, beats in this grant, last select
    int m_ch    = -1;
    int m_ptr   = 0;
    int m_beats = 0;
    int m_sel   = 0;

    int    lit_seq  = 0;
    int    lit_done = 0;
    string lit_name = "";
    int    lit_sel, lit_grant, lit_ack, lit_valid;

    function automatic int pick(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (start + k) % 4;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic expect_lit(input string nm, input int s, input int g, input int a, input int v);
        lit_name  = nm;
        lit_sel   = s;
        lit_grant = g;
        lit_ack   = a;
        lit_valid = v;
        lit_seq++;
    endtask

    task automatic step(input logic [3:0] r, input logic rdy);
        @(posedge clk);
        #1;
        req       = r;
        out_ready = rdy;
    endtask

    always @(negedge clk) begin
        int e_valid, e_grant, e_ack, w;
        if (lit_seq != lit_done) begin
            if (lit_sel >= 0) chk({"lit.", lit_name, ".sel"}, int'(sel), lit_sel);
            chk({"lit.", lit_name, ".grant"}, int'(grant), lit_grant);
            chk({"lit.", lit_name, ".ack"}, int'(ack), lit_ack);
            chk({"lit.", lit_name, ".out_valid"}, int'(out_valid), lit_valid);
            lit_done = lit_seq;
        end
        if (rst) begin
            m_ch    = -1;
            m_ptr   = 0;
            m_beats = 0;
            m_sel   = 0;
        end else begin
            e_valid = (m_ch >= 0) ? int'(req[m_ch]) : 0;
            e_grant = (m_ch >= 0) ? (1 << m_ch) : 0;
            e_ack   = (e_valid == 1 && out_ready) ? e_grant : 0;
            chk("model.sel", int'(sel), m_sel);
            chk("model.grant", int'(grant), e_grant);
            chk("model.ack", int'(ack), e_ack);
            chk("model.out_valid", int'(out_valid), e_valid);
            w = -2;
            if (m_ch < 0) begin
                if (req != 4'd0) w = pick(req, m_ptr);
            end else if (e_valid == 1 && out_ready) begin
                m_ptr = (m_ch + 1) % 4;
                m_beats++;
                if (m_beats >= MAXB) w = pick(req & ~4'(e_grant), m_ptr);
            end else if (e_valid == 0) begin
                w = pick(req & ~4'(e_grant), m_ptr);
            end
            if (w != -2) begin
                m_ch = w;
                if (w >= 0) begin
                    m_sel   = w;
                    m_beats = 0;
                end
            end
        end
    end

    initial begin
        logic [3:0] pa, r;
        step(4'b0000, 1'b0);
        expect_lit("reset", 0, 0, 0, 0);
        step(4'b0000, 1'b0);
        rst = 1'b0;
        expect_lit("idle_after_rst", 0, 0, 0, 0);
`ifndef SCHED_BURST_EN
        step(4'b1111, 1'b1);
        expect_lit("rr_idle", -1, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 1'b1);
            expect_lit("rr_seq", k % 4, 1 << (k % 4), 1 << (k % 4), 1);
        end
        step(4'b0100, 1'b0);
        expect_lit("bp_drop", 1, 2, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(4'b0100, 1'b0);
            expect_lit("bp_hold", 2, 4, 0, 1);
        end
        step(4'b0100, 1'b1);
        expect_lit("bp_release", 2, 4, 4, 1);
        step(4'b1001, 1'b0);
        expect_lit("wrap_idle", -1, 0, 0, 0);
        step(4'b1001, 1'b1);
        expect_lit("wrap_prio", 3, 8, 8, 1);
        step(4'b0001, 1'b1);
        expect_lit("wrap_then0", 0, 1, 1, 1);
        step(4'b0001, 1'b1);
        expect_lit("sole_gap", -1, 0, 0, 0);
        step(4'b0001, 1'b1);
        expect_lit("sole_regain", 0, 1, 1, 1);
        step(4'b0100, 1'b0);
        expect_lit("idle_again", -1, 0, 0, 0);
        step(4'b0100, 1'b0);
        expect_lit("pre_rst", 2, 4, 0, 1);
`else
        step(4'b1010, 1'b1);
        expect_lit("burst_idle", -1, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step(4'b1010, 1'b1);
            expect_lit("burst_ch1", 1, 2, 2, 1);
        end
        step(4'b1010, 1'b1);
        expect_lit("burst_next", 3, 8, 8, 1);
        step(4'b0010, 1'b1);
        expect_lit("early_drop3", 3, 8, 0, 0);
        step(4'b0010, 1'b1);
        expect_lit("early_b1", 1, 2, 2, 1);
        step(4'b0010, 1'b1);
        expect_lit("early_b2", 1, 2, 2, 1);
        step(4'b1000, 1'b1);
        expect_lit("early_stop", 1, 2, 0, 0);
        step(4'b1000, 1'b1);
        expect_lit("early_rearb", 3, 8, 8, 1);
        step(4'b0100, 1'b0);
        expect_lit("pre_rst_drop", 3, 8, 0, 0);
        step(4'b0100, 1'b0);
        expect_lit("pre_rst", 2, 4, 0, 1);
`endif
        @(posedge clk);
        #3;
        rst = 1'b1;
        req = 4'b1111;
        expect_lit("async_rst", 0, 0, 0, 0);
        step(4'b1111, 1'b0);
        rst = 1'b0;
        expect_lit("post_rst_idle", 0, 0, 0, 0);
        step(4'b1111, 1'b0);
        expect_lit("post_rst_grant", 0, 1, 0, 1);

        for (int n = 0; n < 3000; n++) begin
            #2;
            pa = ack;
            r  = req;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (r[i] && !pa[i]) begin
                    if ($urandom_range(0, 31) == 0) r[i] = 1'b0;
                end else begin
                    r[i] = 1'($urandom_range(0, 1));
                end
            end
            req       = r;
            out_ready = ($urandom_range(0, 3) != 0);
        end
        step(4'b0000, 1'b0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
